// File: rtl/alu_share_arbiter.sv
// Two-requester round-robin front end for one shared combinational ALU.
// Operands are registered onto the ALU, held for a settle window, and the result is returned with a valid/ready handshake.
module alu_share_arbiter #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [5:0]  req0_opcode,
  input  logic [5:0]  req0_funct,
  input  logic [4:0]  req0_shamt,
  input  logic [15:0] req0_imm,
  input  logic [31:0] req0_rs,
  input  logic [31:0] req0_rt,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [5:0]  req1_opcode,
  input  logic [5:0]  req1_funct,
  input  logic [4:0]  req1_shamt,
  input  logic [15:0] req1_imm,
  input  logic [31:0] req1_rs,
  input  logic [31:0] req1_rt,
  output logic [5:0]  alu_opcode,
  output logic [5:0]  alu_funct,
  output logic [4:0]  alu_shamt,
  output logic [15:0] alu_imm,
  output logic [31:0] alu_rs,
  output logic [31:0] alu_rt,
  input  logic [31:0] alu_result,
  input  logic        alu_branch,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_result,
  output logic        resp_branch
);

  localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYCLES);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t     state, state_next;
  logic       rr_ptr;
  logic [3:0] cnt;
  logic       grant0, grant1, accept;
  logic       is_branch_op;

  // rr_ptr only breaks ties; a lone valid requester is always granted
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == IDLE) begin
      if (req0_valid && (!req1_valid || !rr_ptr))
        grant0 = 1'b1;
      else if (req1_valid)
        grant1 = 1'b1;
    end
  end

  assign req0_ready   = grant0;
  assign req1_ready   = grant1;
  assign accept       = grant0 | grant1;
  assign is_branch_op = (alu_opcode == 6'h04) || (alu_opcode == 6'h05);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = EXEC;
      EXEC:    if (cnt == 4'd1) state_next = RESP;
      RESP:    if (resp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= 1'b0;
      cnt         <= 4'd0;
      alu_opcode  <= 6'd0;
      alu_funct   <= 6'd0;
      alu_shamt   <= 5'd0;
      alu_imm     <= 16'd0;
      alu_rs      <= 32'd0;
      alu_rt      <= 32'd0;
      resp_valid  <= 1'b0;
      resp_id     <= 1'b0;
      resp_result <= 32'd0;
      resp_branch <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant1) begin
            alu_opcode <= req1_opcode;
            alu_funct  <= req1_funct;
            alu_shamt  <= req1_shamt;
            alu_imm    <= req1_imm;
            alu_rs     <= req1_rs;
            alu_rt     <= req1_rt;
            resp_id    <= 1'b1;
            rr_ptr     <= 1'b0;
            cnt        <= SETTLE_INIT;
          end else if (grant0) begin
            alu_opcode <= req0_opcode;
            alu_funct  <= req0_funct;
            alu_shamt  <= req0_shamt;
            alu_imm    <= req0_imm;
            alu_rs     <= req0_rs;
            alu_rt     <= req0_rt;
            resp_id    <= 1'b0;
            rr_ptr     <= 1'b1;
            cnt        <= SETTLE_INIT;
          end
        end
        EXEC: begin
          cnt <= cnt - 4'd1;
          // sig_branch is meaningless for non-branch opcodes, so mask it
          if (cnt == 4'd1) begin
            resp_result <= alu_result;
            resp_branch <= is_branch_op ? alu_branch : 1'b0;
            resp_valid  <= 1'b1;
          end
        end
        RESP: begin
          if (resp_ready)
            resp_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
